// File: rtl/data_mem_bridge.sv
// data_mem_bridge
//   Bridges the core's single-cycle load/store port to a request/ack memory
//   bus. A request seen in IDLE stalls the core at once, is latched, and is
//   held on the bus in BUSY until the slave acks or errors, or until the
//   timeout runs out. DONE releases the stall for one cycle with the result
//   word, then the bridge returns to IDLE.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   core_addr/wdata/we/re     core request (byte address, lane data, byte enables, load)
//   core_rdata, core_stall    load word returned to the core, pipeline freeze
//   bus_req/addr/be/we/wdata  registered bus request, stable while BUSY
//   bus_ack, bus_rdata        slave completion and load data
//   bus_err                   slave error completion
//   err_sticky, err_addr      latched error/timeout flag and first failing address

module data_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_we,
  input  logic        core_re,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        err_sticky,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter is cleared on BUSY entry and holds the number of BUSY cycles
  // already spent, so the last allowed cycle is the one where it equals
  // TIMEOUT_CYCLES-1.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_WORD = 32'hDEAD_BEEF;

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic [31:0] data_q;
  logic [31:0] lat_addr;   // unaligned core address, kept for err_addr
  logic        req_seen;
  logic        is_store;
  logic        timeout_hit;

  assign req_seen    = core_re | (|core_we);
  assign is_store    = |core_we;
  assign timeout_hit = (cnt == CNT_LAST);
  assign core_rdata  = data_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and stall. bus_ack/bus_err only matter in BUSY; DONE never
  // looks at the core request, so a held request is not reissued.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch
    // is inferred.
    state_next = state;
    core_stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_seen) begin
          core_stall = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        core_stall = 1'b1;
        if (bus_ack || bus_err || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Reset abandons any transfer and must not hold the core frozen.
    if (rst) core_stall = 1'b0;
  end

  // Request latch, completion capture, timeout counter and error log.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= 4'b0000;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      lat_addr   <= 32'h0;
      data_q     <= 32'h0;
      cnt        <= 16'h0;
      err_sticky <= 1'b0;
      err_addr   <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_seen) begin
            bus_req   <= 1'b1;
            bus_addr  <= {core_addr[31:2], 2'b00};
            bus_wdata <= core_wdata;
            lat_addr  <= core_addr;
            cnt       <= 16'h0;
            // A store wins over a simultaneous load.
            bus_we    <= is_store;
            bus_be    <= is_store ? core_we : 4'b1111;
          end
        end
        BUSY: begin
          // Completion priority: ack, then err, then timeout.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) data_q <= bus_rdata;
          end else if (bus_err || timeout_hit) begin
            bus_req    <= 1'b0;
            data_q     <= bus_err ? 32'h0 : TIMEOUT_WORD;
            err_sticky <= 1'b1;
            if (!err_sticky) err_addr <= lat_addr;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge
//   Directed bench for data_mem_bridge. Expected load words are pushed to a
//   scoreboard queue when a request is driven and popped when the bridge
//   releases the stall. A second instance with TIMEOUT_CYCLES=4 exercises
//   the timeout path. Inputs change 1 ns after the rising edge; outputs are
//   sampled on the falling edge.

module tb_data_mem_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_we;
  logic        core_re;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        err_sticky;
  logic [31:0] err_addr;

  // Timeout instance: own request inputs, slave never answers.
  logic [31:0] t_addr;
  logic        t_re;
  logic [3:0]  t_we;
  logic [31:0] t_wdata;
  logic        t_ack;
  logic        t_err;
  logic [31:0] t_brdata;
  logic [31:0] t_rdata;
  logic        t_stall;
  logic        t_req;
  logic [31:0] t_baddr;
  logic [3:0]  t_be;
  logic        t_bwe;
  logic [31:0] t_bwdata;
  logic        t_err_sticky;
  logic [31:0] t_err_addr;

  int errors = 0;
  int checks = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  logic [31:0] exp_q[$];

  data_mem_bridge dut (
    .clk(clk), .rst(rst),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we), .core_re(core_re),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_be(bus_be), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .err_sticky(err_sticky), .err_addr(err_addr)
  );

  data_mem_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst),
    .core_addr(t_addr), .core_wdata(t_wdata), .core_we(t_we), .core_re(t_re),
    .core_rdata(t_rdata), .core_stall(t_stall),
    .bus_req(t_req), .bus_addr(t_baddr), .bus_be(t_be), .bus_we(t_bwe),
    .bus_wdata(t_bwdata), .bus_ack(t_ack), .bus_rdata(t_brdata), .bus_err(t_err),
    .err_sticky(t_err_sticky), .err_addr(t_err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare a released word against the oldest scoreboard entry.
  task automatic check_sb(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      check(tag, 64'(obs), 64'(exp_q.pop_front()));
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge (sample point) and track bus_req bursts.
  task automatic mid();
    @(negedge clk);
    if (bus_req && !req_prev) req_rises++;
    req_prev = bus_req;
  endtask

  initial begin
    int stall_n;
    int rises0;
    int t_n;

    rst = 1'b1;
    core_addr = '0; core_wdata = '0; core_we = '0; core_re = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    t_addr = '0; t_re = 1'b0; t_we = '0; t_wdata = '0;
    t_ack = 1'b0; t_err = 1'b0; t_brdata = '0;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mid();
    check("rst_stall", 64'(core_stall), 64'h0);
    check("rst_req", 64'(bus_req), 64'h0);
    check("rst_bus_fields", 64'({bus_we, bus_be, bus_addr}), 64'h0);
    check("rst_wdata", 64'(bus_wdata), 64'h0);
    check("rst_rdata", 64'(core_rdata), 64'h0);
    check("rst_err", 64'({err_sticky, err_addr}), 64'h0);

    // ---- load with immediate ack
    stall_n = 0;
    cyc();
    core_re = 1'b1; core_addr = 32'h0000_1006;
    exp_q.push_back(32'hA1B2_C3D4);
    mid();
    if (core_stall) stall_n++;
    check("ld_detect_stall", 64'(core_stall), 64'h1);
    check("ld_detect_req", 64'(bus_req), 64'h0);
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'hA1B2_C3D4;
    mid();
    if (core_stall) stall_n++;
    check("ld_busy_req", 64'(bus_req), 64'h1);
    check("ld_busy_addr", 64'(bus_addr), 64'h1004);
    check("ld_busy_be_we", 64'({bus_be, bus_we}), 64'({4'b1111, 1'b0}));
    cyc();
    bus_ack = 1'b0; core_re = 1'b0;
    mid();
    if (core_stall) stall_n++;
    check("ld_stall_cycles", 64'(stall_n), 64'd2);
    check("ld_done_req", 64'(bus_req), 64'h0);
    check_sb("ld_done_rdata", core_rdata);
    check("ld_done_err", 64'(err_sticky), 64'h0);

    // ---- byte store, ack on the 5th BUSY cycle
    cyc();
    core_we = 4'b0100; core_wdata = 32'h0055_0000; core_addr = 32'h0000_2003;
    rises0 = req_rises;
    exp_q.push_back(32'hA1B2_C3D4);   // store leaves the data register alone
    mid();
    check("st_detect_stall", 64'(core_stall), 64'h1);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      bus_ack = (i == 5);
      mid();
      check($sformatf("st_busy%0d_fields", i), 64'({bus_req, bus_we, bus_be, bus_addr}),
            64'({1'b1, 1'b1, 4'b0100, 32'h0000_2000}));
      check($sformatf("st_busy%0d_wdata", i), 64'(bus_wdata), 64'h0055_0000);
      check($sformatf("st_busy%0d_stall", i), 64'(core_stall), 64'h1);
    end
    cyc();
    bus_ack = 1'b0; core_we = 4'b0000;
    mid();
    check("st_done_stall", 64'(core_stall), 64'h0);
    check("st_done_req", 64'(bus_req), 64'h0);
    check_sb("st_done_rdata", core_rdata);
    check("st_req_bursts", 64'(req_rises - rises0), 64'd1);

    // ---- ack and err together: ack wins
    cyc();
    core_re = 1'b1; core_addr = 32'h0000_3000;
    exp_q.push_back(32'h1357_2468);
    mid();
    cyc();
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1357_2468;
    mid();
    cyc();
    bus_ack = 1'b0; bus_err = 1'b0; core_re = 1'b0;
    mid();
    check_sb("ackerr_rdata", core_rdata);
    check("ackerr_sticky", 64'(err_sticky), 64'h0);

    // ---- bus error, then a second error that must not move err_addr
    cyc();
    core_re = 1'b1; core_addr = 32'h0000_4009;
    exp_q.push_back(32'h0);
    mid();
    cyc();
    bus_err = 1'b1; bus_rdata = 32'h9999_9999;
    mid();
    check("err_busy_sticky", 64'(err_sticky), 64'h0);
    cyc();
    bus_err = 1'b0; core_re = 1'b0;
    mid();
    check_sb("err_rdata", core_rdata);
    check("err_sticky", 64'(err_sticky), 64'h1);
    check("err_addr", 64'(err_addr), 64'h4009);
    cyc();
    core_we = 4'b1111; core_wdata = 32'hCAFE_F00D; core_addr = 32'h0000_5000;
    exp_q.push_back(32'h0);
    mid();
    cyc();
    bus_err = 1'b1;
    mid();
    cyc();
    bus_err = 1'b0; core_we = 4'b0000;
    mid();
    check_sb("err2_rdata", core_rdata);
    check("err2_addr_kept", 64'({err_sticky, err_addr}), 64'({1'b1, 32'h0000_4009}));

    // ---- reset on the 2nd BUSY cycle, later ack ignored
    cyc();
    core_re = 1'b1; core_addr = 32'h0000_6000;
    mid();
    cyc();
    mid();
    check("rb_busy1_req", 64'(bus_req), 64'h1);
    cyc();
    rst = 1'b1;
    mid();
    check("rb_rst_stall", 64'(core_stall), 64'h0);
    cyc();
    rst = 1'b0; core_re = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    mid();
    check("rb_after_req_stall", 64'({bus_req, core_stall}), 64'h0);
    check("rb_after_err", 64'(err_sticky), 64'h0);
    cyc();
    bus_ack = 1'b0;
    mid();
    check("rb_ack_ignored_rdata", 64'(core_rdata), 64'h0);
    check("rb_ack_ignored_req", 64'({bus_req, core_stall}), 64'h0);

    // ---- back-to-back: request held through DONE
    cyc();
    core_re = 1'b1; core_addr = 32'h0000_7000;
    exp_q.push_back(32'h1111_1111);
    mid();
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    mid();
    cyc();
    bus_ack = 1'b0;
    mid();
    check("b2b_done_stall", 64'(core_stall), 64'h0);
    check("b2b_done_noreissue", 64'(bus_req), 64'h0);
    check_sb("b2b_done1_rdata", core_rdata);
    cyc();
    core_addr = 32'h0000_7010;
    exp_q.push_back(32'h2222_2222);
    mid();
    check("b2b_new_detect", 64'({core_stall, bus_req}), 64'({1'b1, 1'b0}));
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
    mid();
    check("b2b_new_busy", 64'({bus_req, bus_addr}), 64'({1'b1, 32'h0000_7010}));
    cyc();
    bus_ack = 1'b0; core_re = 1'b0;
    mid();
    check_sb("b2b_done2_rdata", core_rdata);

    // ---- timeout (TIMEOUT_CYCLES=4), slave silent
    cyc();
    t_re = 1'b1; t_addr = 32'h0000_8006;
    exp_q.push_back(32'hDEAD_BEEF);
    t_n = 0;
    for (int k = 0; k < 20; k++) begin
      mid();
      if (!t_stall) break;
      t_n++;
      if (t_n == 5) check("to_last_busy_sticky", 64'(t_err_sticky), 64'h0);
      cyc();
    end
    check("to_bound", 64'(t_stall), 64'h0);
    check("to_stall_cycles", 64'(t_n), 64'd5);
    check("to_done_req", 64'(t_req), 64'h0);
    check_sb("to_rdata", t_rdata);
    check("to_sticky", 64'(t_err_sticky), 64'h1);
    check("to_err_addr", 64'(t_err_addr), 64'h8006);
    cyc();
    t_re = 1'b0;
    mid();
    check("to_idle_stall", 64'(t_stall), 64'h0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
